// File: rtl/microop_sequencer.sv
// Expands each accepted instruction into 1..8 micro-ops and checks them against an external step counter.
// Latency: accept -> SYNC cycle -> first micro-op (2 cycles); a chained instruction with len != 0 follows with no bubble.
// Backpressure: inst_ready is high only in IDLE or on the last micro-op; an offer made while it is low is held by the source.
module microop_sequencer #(
  parameter int OPCODE_W = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_valid,
  output logic                inst_ready,
  input  logic [OPCODE_W-1:0] inst_opcode,
  input  logic [2:0]          inst_len,
  input  logic [2:0]          count,
  output logic                inst_done,
  output logic                uop_valid,
  output logic [OPCODE_W-1:0] uop_opcode,
  output logic [2:0]          uop_step,
  output logic                uop_last,
  output logic                seq_err
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_SYNC,
    S_EXEC
  } state_t;

  state_t              state_q, state_d;
  logic [OPCODE_W-1:0] lat_op_q, lat_op_d;     // opcode of the instruction being sequenced
  logic [2:0]          lat_len_q, lat_len_d;   // its length minus one
  logic [OPCODE_W-1:0] op_q, op_d;             // opcode shown on uop_opcode, held outside EXEC
  logic [2:0]          step_q, step_d;
  logic                done_q, done_d;
  logic                valid_q, valid_d;
  logic                last_q, last_d;
  logic                err_q, err_d;

  logic                accept;
  logic [2:0]          count_val;
  logic [2:0]          step_inc;

  // count[0] carries the MSB of the counter value, so reorder into a normal number
  assign count_val  = {count[0], count[1], count[2]};
  assign step_inc   = step_q + 3'd1;
  assign inst_ready = (state_q == S_IDLE) || ((state_q == S_EXEC) && last_q);
  assign accept     = inst_valid && inst_ready;

  assign inst_done  = done_q;
  assign uop_valid  = valid_q;
  assign uop_last   = last_q;
  assign uop_opcode = op_q;
  assign uop_step   = step_q;
  assign seq_err    = err_q;

  // Next state plus next registered outputs; all outputs are decoded one cycle early so they come straight from flops
  always_comb begin
    state_d   = state_q;
    lat_op_d  = lat_op_q;
    lat_len_d = lat_len_q;
    op_d      = op_q;
    step_d    = step_q;
    err_d     = err_q;
    done_d    = 1'b0;
    valid_d   = 1'b0;
    last_d    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          lat_op_d  = inst_opcode;
          lat_len_d = inst_len;
          state_d   = S_SYNC;
          done_d    = 1'b1;   // SYNC raises inst_done so the counter reloads
        end
      end

      S_GAP: begin
        // one low cycle of inst_done so the following SYNC is a real rising edge
        state_d = S_SYNC;
        done_d  = 1'b1;
      end

      S_SYNC: begin
        state_d = S_EXEC;
        op_d    = lat_op_q;
        step_d  = 3'd0;
        valid_d = 1'b1;
        last_d  = (lat_len_q == 3'd0);
        done_d  = (lat_len_q == 3'd0);
      end

      S_EXEC: begin
        // mismatch is flagged but never alters sequencing
        if (count_val != step_q) begin
          err_d = 1'b1;
        end
        if (!last_q) begin
          // step < len here, so the increment cannot wrap
          step_d  = step_inc;
          valid_d = 1'b1;
          last_d  = (step_inc == lat_len_q);
          done_d  = (step_inc == lat_len_q);
        end else if (accept) begin
          lat_op_d  = inst_opcode;
          lat_len_d = inst_len;
          if (inst_len != 3'd0) begin
            // inst_done was high on this step and drops next, giving a fresh edge later
            state_d = S_EXEC;
            op_d    = inst_opcode;
            step_d  = 3'd0;
            valid_d = 1'b1;
          end else begin
            // a single-step successor would keep inst_done high with no edge; insert GAP
            state_d = S_GAP;
          end
        end else begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous reset taking priority over everything
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      lat_op_q  <= '0;
      lat_len_q <= 3'd0;
      op_q      <= '0;
      step_q    <= 3'd0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      lat_op_q  <= lat_op_d;
      lat_len_q <= lat_len_d;
      op_q      <= op_d;
      step_q    <= step_d;
      done_q    <= done_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      err_q     <= err_d;
    end
  end

endmodule

// File: tb/tb_microop_sequencer.sv
// Bench for microop_sequencer: schedule-based reference model, external step counter, directed and random traffic.
// One cycle task drives inputs 1 ns after the rising edge and checks every output on the falling edge.
// The instruction source holds an offer until the model reports it accepted.
module tb_microop_sequencer;
  localparam int OW = 4;
  localparam int KIDLE = 0;
  localparam int KGAP  = 1;
  localparam int KSYNC = 2;
  localparam int KEXEC = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          inst_valid;
  logic          inst_ready;
  logic [OW-1:0] inst_opcode;
  logic [2:0]    inst_len;
  logic [2:0]    count;
  logic          inst_done;
  logic          uop_valid;
  logic [OW-1:0] uop_opcode;
  logic [2:0]    uop_step;
  logic          uop_last;
  logic          seq_err;

  microop_sequencer #(.OPCODE_W(OW)) dut (
    .clk(clk), .rst(rst), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_opcode(inst_opcode), .inst_len(inst_len), .count(count),
    .inst_done(inst_done), .uop_valid(uop_valid), .uop_opcode(uop_opcode),
    .uop_step(uop_step), .uop_last(uop_last), .seq_err(seq_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // one record per future cycle of the current instruction
  typedef struct {
    int            kind;
    logic [OW-1:0] op;
    logic [2:0]    step;
    bit            last;
  } rec_t;

  rec_t          sched[$];
  logic [OW-1:0] held_op;
  logic [2:0]    held_step;
  bit            err_m;

  // external micro-op counter: reloads 0 on the edge after inst_done rises, else counts up
  logic [2:0]    cnt;
  bit            done_prev;
  bit            force_en;
  logic [2:0]    force_val;
  logic [2:0]    cnt_drv;

  function automatic logic [2:0] brev(input logic [2:0] v);
    return {v[0], v[1], v[2]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // append the cycles an accepted instruction will occupy
  task automatic push_instr(input bit from_idle, input logic [OW-1:0] op, input logic [2:0] len);
    rec_t r;
    r.op = op; r.step = 3'd0; r.last = 1'b0;
    if (!from_idle && len == 3'd0) begin
      r.kind = KGAP;  sched.push_back(r);
    end
    if (from_idle || len == 3'd0) begin
      r.kind = KSYNC; sched.push_back(r);
    end
    for (int s = 0; s <= int'(len); s++) begin
      r.kind = KEXEC;
      r.step = 3'(s);
      r.last = (s == int'(len));
      sched.push_back(r);
    end
  endtask

  task automatic cycle(input bit v, input logic [OW-1:0] op, input logic [2:0] len,
                       input bit r, output bit acc);
    rec_t cur;
    bit   e_valid, e_last, e_done, e_ready;
    @(posedge clk);
    #1;
    rst         = r;
    inst_valid  = v;
    inst_opcode = op;
    inst_len    = len;
    cnt_drv     = force_en ? force_val : cnt;
    count       = brev(cnt_drv);
    @(negedge clk);
    if (sched.size() != 0) cur = sched[0];
    else begin
      cur.kind = KIDLE; cur.op = '0; cur.step = 3'd0; cur.last = 1'b0;
    end
    e_valid = (cur.kind == KEXEC);
    e_last  = e_valid && cur.last;
    e_done  = (cur.kind == KSYNC) || e_last;
    e_ready = (cur.kind == KIDLE) || e_last;
    chk("inst_ready", 32'(inst_ready), 32'(e_ready));
    chk("inst_done",  32'(inst_done),  32'(e_done));
    chk("uop_valid",  32'(uop_valid),  32'(e_valid));
    chk("uop_last",   32'(uop_last),   32'(e_last));
    chk("uop_opcode", 32'(uop_opcode), 32'(e_valid ? cur.op : held_op));
    chk("uop_step",   32'(uop_step),   32'(e_valid ? cur.step : held_step));
    chk("seq_err",    32'(seq_err),    32'(err_m));
    acc = v && e_ready && !r;
    if (r) begin
      sched.delete();
      held_op = '0; held_step = 3'd0; err_m = 1'b0;
    end else begin
      if (e_valid) begin
        if (cnt_drv != cur.step) err_m = 1'b1;
        held_op   = cur.op;
        held_step = cur.step;
      end
      if (sched.size() != 0) sched.delete(0);
      if (acc) push_instr(cur.kind == KIDLE, op, len);
    end
    cnt       = (inst_done && !done_prev) ? 3'd0 : cnt + 3'd1;
    done_prev = inst_done;
  endtask

  task automatic idle(input int n);
    bit a;
    for (int i = 0; i < n; i++) cycle(1'b0, '0, 3'd0, 1'b0, a);
  endtask

  bit            a;
  bit            have_offer;
  logic [OW-1:0] r_op;
  logic [2:0]    r_len;

  initial begin
    rst = 1'b1; inst_valid = 1'b0; inst_opcode = '0; inst_len = 3'd0; count = 3'd0;
    cnt = 3'd0; done_prev = 1'b0; force_en = 1'b0; force_val = 3'd0; cnt_drv = 3'd0;
    held_op = '0; held_step = 3'd0; err_m = 1'b0;
    repeat (2) @(posedge clk);

    // reset state, then single instruction opcode 5 len 2
    cycle(1'b1, 4'd5, 3'd2, 1'b0, a);
    chk("reset_ready", 32'(inst_ready), 32'd1);
    chk("reset_done",  32'(inst_done),  32'd0);
    cycle(1'b0, '0, 3'd0, 1'b0, a);                 // SYNC
    chk("sync_done",  32'(inst_done), 32'd1);
    chk("sync_valid", 32'(uop_valid), 32'd0);
    cycle(1'b0, '0, 3'd0, 1'b0, a);                 // step 0
    chk("s0_step", 32'(uop_step),   32'd0);
    chk("s0_op",   32'(uop_opcode), 32'd5);
    chk("s0_done", 32'(inst_done),  32'd0);
    cycle(1'b0, '0, 3'd0, 1'b0, a);                 // step 1
    cycle(1'b0, '0, 3'd0, 1'b0, a);                 // step 2
    chk("s2_last", 32'(uop_last),  32'd1);
    chk("s2_done", 32'(inst_done), 32'd1);
    cycle(1'b0, '0, 3'd0, 1'b0, a);                 // IDLE
    chk("end_valid", 32'(uop_valid), 32'd0);
    chk("end_err",   32'(seq_err),   32'd0);

    // back-to-back: len 1 accepted on the last step of len 3
    cycle(1'b1, 4'd9, 3'd3, 1'b0, a);
    for (int i = 0; i < 5; i++) cycle(1'b1, 4'd6, 3'd1, 1'b0, a); // SYNC, steps 0..3
    chk("b2b_acc", 32'(a), 32'd1);
    cycle(1'b0, '0, 3'd0, 1'b0, a);
    chk("b2b_valid", 32'(uop_valid),  32'd1);
    chk("b2b_op",    32'(uop_opcode), 32'd6);
    chk("b2b_step",  32'(uop_step),   32'd0);
    chk("b2b_done",  32'(inst_done),  32'd0);
    cycle(1'b0, '0, 3'd0, 1'b0, a);
    chk("b2b_done1", 32'(inst_done), 32'd1);
    idle(2);

    // len 0 chained on the last step: done pattern 1,0,1,1
    cycle(1'b1, 4'd2, 3'd1, 1'b0, a);
    cycle(1'b1, 4'd3, 3'd0, 1'b0, a);               // SYNC
    cycle(1'b1, 4'd3, 3'd0, 1'b0, a);               // step 0
    cycle(1'b1, 4'd3, 3'd0, 1'b0, a);               // step 1, accepted
    chk("z_done_a", 32'(inst_done), 32'd1);
    cycle(1'b0, '0, 3'd0, 1'b0, a);                 // GAP
    chk("z_done_b", 32'(inst_done), 32'd0);
    chk("z_gap_valid", 32'(uop_valid), 32'd0);
    cycle(1'b0, '0, 3'd0, 1'b0, a);                 // SYNC
    chk("z_done_c", 32'(inst_done), 32'd1);
    cycle(1'b0, '0, 3'd0, 1'b0, a);                 // single EXEC
    chk("z_done_d", 32'(inst_done), 32'd1);
    chk("z_last",   32'(uop_last),  32'd1);
    chk("z_op",     32'(uop_opcode), 32'd3);
    idle(1);
    chk("z_err", 32'(seq_err), 32'd0);

    // forced mismatch at step 1, sticky until reset
    cycle(1'b1, 4'd7, 3'd3, 1'b0, a);
    idle(2);                                        // SYNC, step 0
    force_en = 1'b1; force_val = 3'd3;
    idle(1);                                        // step 1
    force_en = 1'b0;
    idle(1);
    chk("mm_err", 32'(seq_err), 32'd1);
    idle(2);
    cycle(1'b1, 4'd1, 3'd0, 1'b0, a);
    idle(3);
    chk("mm_sticky", 32'(seq_err), 32'd1);
    cycle(1'b0, '0, 3'd0, 1'b1, a);
    idle(1);
    chk("mm_clear", 32'(seq_err), 32'd0);

    // reset in the middle of a len 5 instruction, then realign from count 6
    cycle(1'b1, 4'd4, 3'd5, 1'b0, a);
    idle(2);
    cycle(1'b0, '0, 3'd0, 1'b1, a);                 // step 1 with rst
    cnt = 3'd6;
    cycle(1'b1, 4'd8, 3'd2, 1'b0, a);
    chk("rm_ready", 32'(inst_ready), 32'd1);
    chk("rm_op",    32'(uop_opcode), 32'd0);
    chk("rm_step",  32'(uop_step),   32'd0);
    chk("rm_done",  32'(inst_done),  32'd0);
    idle(5);
    chk("rm_err", 32'(seq_err), 32'd0);

    // maximum length
    cycle(1'b1, 4'd15, 3'd7, 1'b0, a);
    idle(8);                                        // SYNC, steps 0..6
    chk("max_s6_last", 32'(uop_last), 32'd0);
    idle(1);
    chk("max_s7_step", 32'(uop_step), 32'd7);
    chk("max_s7_last", 32'(uop_last), 32'd1);
    idle(1);
    chk("max_hold_step", 32'(uop_step), 32'd7);
    chk("max_err",       32'(seq_err),  32'd0);

    // random traffic with held offers, sporadic resets and count glitches
    have_offer = 1'b0; r_op = '0; r_len = 3'd0;
    for (int i = 0; i < 3000; i++) begin
      if (!have_offer && ($urandom_range(0, 2) == 0)) begin
        have_offer = 1'b1;
        r_op  = 4'($urandom);
        r_len = ($urandom_range(0, 3) == 0) ? 3'd0 : 3'($urandom);
      end
      force_en  = ($urandom_range(0, 60) == 0);
      force_val = 3'($urandom);
      cycle(have_offer, r_op, r_len, ($urandom_range(0, 250) == 0), a);
      if (a) have_offer = 1'b0;
    end
    force_en = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
